// File: rtl/motor_puertas.sv
// +--------------------------------------------------------------------------+
// | motor_puertas                                                            |
// | Door actuator/timer: drives the door motor, tracks door position and     |
// | dwell time. Option macro: MOTOR_PUERTAS_REVERSA_EN (sensor reverses a    |
// | closing door).                                                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module motor_puertas #(
  parameter int T_RECORRIDO = 4,
  parameter int T_ESPERA    = 10,
  parameter int CW          = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] salida_puertas,
  input  logic       sensor,
  output logic [1:0] puertas,
  output logic       timeout,
  output logic [1:0] motor
);

  typedef enum logic [1:0] {
    CERRADA  = 2'b00,
    ABRIENDO = 2'b10,
    ABIERTA  = 2'b01,
    CERRANDO = 2'b11
  } state_t;

  localparam logic [CW-1:0] c_T_REC  = CW'(T_RECORRIDO);
  localparam logic [CW-1:0] c_T_ESP  = CW'(T_ESPERA);
  localparam logic [CW-1:0] c_ZERO   = '0;
  localparam logic [CW-1:0] c_ONE    = CW'(1);
  localparam logic [1:0]    c_M_OPEN  = 2'b01;
  localparam logic [1:0]    c_M_CLOSE = 2'b10;
  localparam logic [1:0]    c_M_STOP  = 2'b00;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_next;
  logic [CW-1:0] r_espera;
  logic [CW-1:0] w_espera_next;
  logic [1:0]    r_motor;
  logic          r_timeout;
  logic          w_cmd_open;
  logic          w_cmd_close;
  logic          w_sensor_rev;
  logic [1:0]    w_motor_next;
  logic          w_timeout_next;

  assign w_cmd_open  = (salida_puertas == 2'b01);
  assign w_cmd_close = (salida_puertas == 2'b10);

`ifdef MOTOR_PUERTAS_REVERSA_EN
  assign w_sensor_rev = sensor;
`else
  assign w_sensor_rev = 1'b0;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_pos_next    = r_pos;
    w_espera_next = c_ZERO;
    case (r_state)
      CERRADA: begin
        w_pos_next = c_ZERO;
        if (w_cmd_open) begin
          w_state_next = ABRIENDO;
        end
      end
      ABRIENDO: begin
        // Opening always completes; close commands have no effect here.
        w_pos_next = r_pos + c_ONE;
        if ((r_pos + c_ONE) == c_T_REC) begin
          w_state_next = ABIERTA;
        end
      end
      ABIERTA: begin
        if (sensor || w_cmd_open) begin
          w_espera_next = c_ZERO;
        end else if (w_cmd_close) begin
          w_state_next = CERRANDO;
        end else if (r_espera != c_T_ESP) begin
          w_espera_next = r_espera + c_ONE;
        end else begin
          w_espera_next = r_espera;
        end
      end
      CERRANDO: begin
        // Reversal keeps the current position so reopening is partial.
        if (w_sensor_rev || w_cmd_open) begin
          w_state_next = ABRIENDO;
        end else begin
          w_pos_next = r_pos - c_ONE;
          if ((r_pos - c_ONE) == c_ZERO) begin
            w_state_next = CERRADA;
          end
        end
      end
      default: begin
        w_state_next = CERRADA;
        w_pos_next   = c_ZERO;
      end
    endcase
  end

  always_comb begin
    w_motor_next = c_M_STOP;
    if (w_state_next == ABRIENDO) begin
      w_motor_next = c_M_OPEN;
    end else if (w_state_next == CERRANDO) begin
      w_motor_next = c_M_CLOSE;
    end
    w_timeout_next = (w_state_next == ABIERTA) && (w_espera_next == c_T_ESP);
  end

  // Outputs are registered from the next-state values so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CERRADA;
      r_pos     <= c_ZERO;
      r_espera  <= c_ZERO;
      r_motor   <= c_M_STOP;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pos     <= w_pos_next;
      r_espera  <= w_espera_next;
      r_motor   <= w_motor_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign puertas = r_state;
  assign motor   = r_motor;
  assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_motor_puertas.sv
// +--------------------------------------------------------------------------+
// | tb_motor_puertas                                                         |
// | Directed, table-driven bench for motor_puertas with default parameters.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_motor_puertas;

  logic       clk;
  logic       rst_n;
  logic [1:0] salida_puertas;
  logic       sensor;
  logic [1:0] puertas;
  logic       timeout;
  logic [1:0] motor;

  int n_tests;
  int n_fail;

  motor_puertas #(
    .T_RECORRIDO(4),
    .T_ESPERA   (10),
    .CW         (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .salida_puertas(salida_puertas),
    .sensor        (sensor),
    .puertas       (puertas),
    .timeout       (timeout),
    .motor         (motor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] cmd;
    logic       sen;
    int         n;
    logic [1:0] p;
    logic [1:0] m;
    logic       t;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic [1:0] cmd, input logic sen,
                     input int n, input logic [1:0] p, input logic [1:0] m,
                     input logic t);
    vec_t v;
    v.name = name; v.cmd = cmd; v.sen = sen; v.n = n;
    v.p = p; v.m = m; v.t = t;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [1:0] p,
                       input logic [1:0] m, input logic t);
    n_tests++;
    if (puertas !== p || motor !== m || timeout !== t) begin
      n_fail++;
      $display("FAIL %s: got puertas=%b motor=%b timeout=%b, want puertas=%b motor=%b timeout=%b",
               name, puertas, motor, timeout, p, m, t);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    salida_puertas = 2'b00;
    sensor = 1'b0;
    #1;
    check("reset_async", 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_release", 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    salida_puertas = 2'b00;
    sensor  = 1'b0;

    // Open, illegal command, close ignored while opening, timeout.
    add("idle",          2'b00, 1'b0, 2,  2'b00, 2'b00, 1'b0);
    add("cmd11_cerrada", 2'b11, 1'b0, 2,  2'b00, 2'b00, 1'b0);
    add("open_start",    2'b01, 1'b0, 1,  2'b10, 2'b01, 1'b0);
    add("close_ignored", 2'b10, 1'b0, 3,  2'b10, 2'b01, 1'b0);
    add("open_done",     2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b0);
    add("dwell",         2'b00, 1'b0, 9,  2'b01, 2'b00, 1'b0);
    add("timeout_rise",  2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b1);
    add("timeout_hold",  2'b11, 1'b0, 2,  2'b01, 2'b00, 1'b1);
    // Full close.
    add("close_start",   2'b10, 1'b0, 1,  2'b11, 2'b10, 1'b0);
    add("closing",       2'b00, 1'b0, 3,  2'b11, 2'b10, 1'b0);
    add("closed",        2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0);
    // Command 01 reverses at pos 3.
    add("reopen",        2'b01, 1'b0, 1,  2'b10, 2'b01, 1'b0);
    add("reopening",     2'b00, 1'b0, 3,  2'b10, 2'b01, 1'b0);
    add("reopened",      2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b0);
    add("close2_start",  2'b10, 1'b0, 1,  2'b11, 2'b10, 1'b0);
    add("close2_pos3",   2'b00, 1'b0, 1,  2'b11, 2'b10, 1'b0);
    add("rev_cmd_pos3",  2'b01, 1'b0, 1,  2'b10, 2'b01, 1'b0);
    add("rev_cmd_open",  2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b0);
    // Sensor hold with close command, then dwell restart.
    add("pre_dwell",     2'b00, 1'b0, 5,  2'b01, 2'b00, 1'b0);
    add("sensor_hold",   2'b10, 1'b1, 30, 2'b01, 2'b00, 1'b0);
    add("post_sensor",   2'b00, 1'b0, 9,  2'b01, 2'b00, 1'b0);
    add("post_timeout",  2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b1);
    add("open_clears",   2'b01, 1'b0, 1,  2'b01, 2'b00, 1'b0);
    add("redwell",       2'b00, 1'b0, 9,  2'b01, 2'b00, 1'b0);
    add("retimeout",     2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b1);
    // Obstruction while closing at pos 2.
    add("close3_start",  2'b10, 1'b0, 1,  2'b11, 2'b10, 1'b0);
    add("close3_run",    2'b00, 1'b0, 2,  2'b11, 2'b10, 1'b0);
`ifdef MOTOR_PUERTAS_REVERSA_EN
    add("sensor_rev",    2'b00, 1'b1, 1,  2'b10, 2'b01, 1'b0);
    add("sensor_rev2",   2'b00, 1'b0, 1,  2'b10, 2'b01, 1'b0);
    add("sensor_rev_op", 2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b0);
`else
    add("sensor_norev",  2'b00, 1'b1, 1,  2'b11, 2'b10, 1'b0);
    add("sensor_norev2", 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0);
    add("sensor_cerr",   2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0);
`endif

    do_reset();

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        salida_puertas = tbl[i].cmd;
        sensor         = tbl[i].sen;
        @(posedge clk); #1;
        check(tbl[i].name, tbl[i].p, tbl[i].m, tbl[i].t);
      end
    end

    // Asynchronous reset while opening at pos 2, then a full-length reopen.
    do_reset();
    salida_puertas = 2'b01;
    @(posedge clk); #1;
    salida_puertas = 2'b00;
    repeat (2) @(posedge clk);
    #3;
    check("pre_reset_abriendo", 2'b10, 2'b01, 1'b0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_travel", 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    salida_puertas = 2'b01;
    @(posedge clk); #1;
    salida_puertas = 2'b00;
    for (int k = 0; k < 4; k++) begin
      check("reopen_after_reset", 2'b10, 2'b01, 1'b0);
      @(posedge clk); #1;
    end
    check("open_after_reset", 2'b01, 2'b00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
